// File: rtl/ddr_bmp_pixel_reader.sv
// Streams a bottom-up 24-bit BMP pixel array out of byte-wide image memory as
// top-down, left-to-right RGB pixels with a valid/ready handshake.
module ddr_bmp_pixel_reader #(
  parameter int HEADER_BYTES = 54,
  parameter int IMG_WIDTH    = 100,
  parameter int IMG_HEIGHT   = 60,
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [7:0]        mem_readdata,
  output logic [23:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD_B   | blue byte address on the bus
  // RD_G   | green byte address on the bus, blue byte captured
  // RD_R   | red byte address on the bus, green byte captured
  // CAP    | red byte captured, pixel complete
  // OUT    | pixel presented, waiting for out_ready

  localparam int ROW_STRIDE = ((3 * IMG_WIDTH + 3) / 4) * 4;
  localparam int COL_W      = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W      = $clog2(IMG_HEIGHT + 1);

  localparam logic [ADDR_W-1:0] LAST_ROW_BASE =
    ADDR_W'(HEADER_BYTES + (IMG_HEIGHT - 1) * ROW_STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_B,
    RD_G,
    RD_R,
    CAP,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_off;
  logic              last_col;
  logic              last_pix;
  logic              xfer;

  assign last_col = (col == LAST_COL);
  assign last_pix = last_col && (row == LAST_ROW);
  assign xfer     = (state == OUT) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_B;
      RD_B:    state_nxt = RD_G;
      RD_G:    state_nxt = RD_R;
      RD_R:    state_nxt = CAP;
      CAP:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = last_pix ? IDLE : RD_B;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is driven only while a read is in flight so the bus idles at zero.
  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    case (state)
      RD_B: begin
        mem_address    = row_base + col_off;
        mem_chipselect = 1'b1;
      end
      RD_G: begin
        mem_address    = row_base + col_off + ADDR_W'(1);
        mem_chipselect = 1'b1;
      end
      RD_R: begin
        mem_address    = row_base + col_off + ADDR_W'(2);
        mem_chipselect = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_clken = busy;
  assign mem_write = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      col_off   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= xfer && last_pix;
      out_valid <= (state_nxt == OUT);

      if (state == IDLE && start) begin
        col      <= '0;
        row      <= '0;
        row_base <= LAST_ROW_BASE;
        col_off  <= '0;
      end

      // Read data lags its address by one cycle, hence capture one state late.
      if (state == RD_G) out_data[7:0]   <= mem_readdata;
      if (state == RD_R) out_data[15:8]  <= mem_readdata;
      if (state == CAP) begin
        out_data[23:16] <= mem_readdata;
        out_sop         <= (row == '0) && (col == '0);
        out_eop         <= last_pix;
      end

      if (xfer) begin
        out_sop <= 1'b0;
        out_eop <= 1'b0;
        if (last_col) begin
          col      <= '0;
          col_off  <= '0;
          row      <= row + ROW_W'(1);
          row_base <= row_base - STRIDE;
        end else begin
          col     <= col + COL_W'(1);
          col_off <= col_off + ADDR_W'(3);
        end
      end
    end
  end

endmodule
